jtopl_dac_serial: RTL and testbench

Serial DAC transmitter for the OPL sound path. It takes the saturated per-sample sum produced by the channel accumulator and converts it to the YM3014-style floating-point word: 10-bit mantissa with the sign bit inverted, plus a 3-bit exponent. It then shifts that word out one bit per clock-enable tick, in fixed-length frames with a load strobe, to drive an external DAC pin pair. It sits after the accumulator and is the last block before the chip's audio pins.

---
 rtl/jtopl_dac_pkg.sv | 16 +
 rtl/jtopl_dac_fmt.sv | 27 ++
 rtl/jtopl_dac_serial.sv | 75 +++++++
 tb/tb_jtopl_dac_serial.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/jtopl_dac_pkg.sv
`timescale 1ns/1ps
// Shared widths, FSM encoding and the packed DAC word for the serial DAC path.
package jtopl_dac_pkg;
  localparam int MANT_W = 10;
  localparam int EXP_W  = 3;
  localparam int WORD_W = 13;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Bit order matches the serial frame: mantissa bits first, then exponent.
  typedef struct packed {
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] mant;
  } dac_word_t;
endpackage

// File: rtl/jtopl_dac_fmt.sv
`timescale 1ns/1ps
// Combinational 16-bit signed sample to YM3014 float word {exp, offset-binary mantissa}.
module jtopl_dac_fmt
  import jtopl_dac_pkg::*;
(
  input  logic [15:0] snd,
  output dac_word_t   word
);

  logic [2:0]        k;
  logic              same;
  logic [MANT_W-1:0] m;

  always_comb begin
    k    = 3'd0;
    same = 1'b1;
    // Count redundant sign bits below the MSB, capped at six.
    for (int i = 14; i >= 9; i--) begin
      if (same && (snd[i] == snd[15])) k = k + 3'd1;
      else                             same = 1'b0;
    end
    m         = MANT_W'(snd >> (3'd6 - k));
    word.e    = 3'd7 - k;
    word.mant = {~m[MANT_W-1], m[MANT_W-2:0]};
  end

endmodule

// File: rtl/jtopl_dac_serial.sv
`timescale 1ns/1ps
// Serial DAC transmitter: pending sample register, frame FSM and slot counter,
// shifting {pad, mantissa LSB-first, exponent LSB-first} out one bit per cen.
module jtopl_dac_serial
  import jtopl_dac_pkg::*;
#(
  parameter int SLOTS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [15:0] snd,
  input  logic        snd_stb,
  output logic        sd,
  output logic        ld,
  output logic        overrun
);

  localparam int             CW   = $clog2(SLOTS);
  localparam int             PAD  = SLOTS - WORD_W;
  localparam logic [CW-1:0]  LAST = CW'(SLOTS - 1);

  dac_word_t     conv, pend, shw, load_w, cur_w;
  logic          fresh;
  logic [0:0]    st;
  logic [CW-1:0] cnt, nxt;
  logic          go, load;

  jtopl_dac_fmt u_fmt (
    .snd  (snd),
    .word (conv)
  );

  function automatic logic slot_bit(input dac_word_t w, input logic [CW-1:0] s);
    logic [3:0] idx;
    if (s < CW'(PAD)) return 1'b0;
    idx = 4'(s - CW'(PAD));
    return w[idx];
  endfunction

  always_comb begin
    go     = (st == ST_RUN) || fresh || snd_stb;
    nxt    = ((st == ST_IDLE) || (cnt == LAST)) ? '0 : cnt + CW'(1);
    load   = cen && go && (nxt == '0);
    // A strobe on the frame-start cycle bypasses the pending register.
    load_w = snd_stb ? conv : (fresh ? pend : shw);
    cur_w  = load ? load_w : shw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= ST_IDLE;
      cnt     <= '0;
      pend    <= '0;
      shw     <= '0;
      fresh   <= 1'b0;
      sd      <= 1'b0;
      ld      <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= snd_stb & fresh;
      if (snd_stb) pend <= conv;
      if (load)         fresh <= 1'b0;
      else if (snd_stb) fresh <= 1'b1;
      if (cen && go) begin
        st  <= ST_RUN;
        cnt <= nxt;
        if (load) shw <= load_w;
        sd  <= slot_bit(cur_w, nxt);
        ld  <= (nxt == LAST);
      end
    end
  end

endmodule

// File: tb/tb_jtopl_dac_serial.sv
`timescale 1ns/1ps
// Directed bench for jtopl_dac_serial (SLOTS=16, cen every 4 clk) plus a converter sweep.
module tb_jtopl_dac_serial;
  import jtopl_dac_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic [15:0] snd = 16'h0;
  logic        snd_stb = 1'b0;
  logic        sd, ld, overrun;

  logic [15:0] fmt_in = 16'h0;
  dac_word_t   fmt_out;

  int tests  = 0;
  int failed = 0;
  int ov_cnt = 0;

  logic [15:0] sds, lds;
  logic        sd_or, ld_or;

  jtopl_dac_serial #(.SLOTS(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .snd     (snd),
    .snd_stb (snd_stb),
    .sd      (sd),
    .ld      (ld),
    .overrun (overrun)
  );

  jtopl_dac_fmt u_fmt (
    .snd  (fmt_in),
    .word (fmt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clk: drive at negedge, sample 1 ns after the rising edge.
  task automatic step(input logic c, input logic s, input logic [15:0] v);
    @(negedge clk);
    cen = c; snd_stb = s; snd = v;
    @(posedge clk);
    #1;
    if (overrun) ov_cnt++;
  endtask

  // One 4-clk cen period, optional strobe on the cen cycle.
  task automatic slot(input logic s, input logic [15:0] v);
    step(1'b1, s, v);
    repeat (3) step(1'b0, 1'b0, 16'h0);
  endtask

  task automatic run_frame(input logic byp, input logic [15:0] bv,
                           input int a1, input logic [15:0] v1,
                           input int a2, input logic [15:0] v2,
                           input int stall_at, input logic [15:0] ef,
                           output logic [15:0] fs, output logic [15:0] fl);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, byp && (i == 0), bv);
      fs[i] = sd;
      fl[i] = ld;
      if (i == stall_at) begin
        repeat (100) step(1'b0, 1'b0, 16'h0);
        chk("stall_sd", {31'd0, sd}, {31'd0, ef[i]});
        chk("stall_ld", {31'd0, ld}, {31'd0, (i == 15)});
      end
      for (int j = 0; j < 3; j++)
        step(1'b0, (j == 0) && ((i == a1) || (i == a2)), (i == a1) ? v1 : v2);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sd", {31'd0, sd}, 32'd0);
    chk("rst_ld", {31'd0, ld}, 32'd0);
    chk("rst_ov", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle without samples: nothing leaves the block
    sd_or = 1'b0; ld_or = 1'b0;
    for (int i = 0; i < 20; i++) begin
      slot(1'b0, 16'h0);
      sd_or |= sd; ld_or |= ld;
    end
    chk("idle_sd", {31'd0, sd_or}, 32'd0);
    chk("idle_ld", {31'd0, ld_or}, 32'd0);

    // Converter sweep: {e, mant}
    fmt_in = 16'h0000; #1; chk("fmt_0000", {19'd0, fmt_out}, 32'h0600);
    fmt_in = 16'h7FFF; #1; chk("fmt_7fff", {19'd0, fmt_out}, 32'h1FFF);
    fmt_in = 16'h8000; #1; chk("fmt_8000", {19'd0, fmt_out}, 32'h1C00);
    fmt_in = 16'h1000; #1; chk("fmt_1000", {19'd0, fmt_out}, 32'h1700);
    fmt_in = 16'h0100; #1; chk("fmt_0100", {19'd0, fmt_out}, 32'h0700);
    fmt_in = 16'hFFFF; #1; chk("fmt_ffff", {19'd0, fmt_out}, 32'h05FF);
    fmt_in = 16'hFE00; #1; chk("fmt_fe00", {19'd0, fmt_out}, 32'h0400);
    fmt_in = 16'h0200; #1; chk("fmt_0200", {19'd0, fmt_out}, 32'h0B00);

    // Single frame of 0x7FFF
    ov_cnt = 0;
    step(1'b0, 1'b1, 16'h7FFF);
    run_frame(1'b0, 16'h0, -1, 16'h0, -1, 16'h0, -1, 16'hFFF8, sds, lds);
    chk("f7fff_sd", {16'd0, sds}, 32'h0000FFF8);
    chk("f7fff_ld", {16'd0, lds}, 32'h00008000);

    // One sample of 0x1000, then repeated frames
    step(1'b0, 1'b1, 16'h1000);
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0, 16'h0, -1, 16'h0, -1, 16'h0, -1, 16'hB800, sds, lds);
      chk("rep_sd", {16'd0, sds}, 32'h0000B800);
      chk("rep_ld", {16'd0, lds}, 32'h00008000);
    end
    chk("rep_ov", ov_cnt, 32'd0);

    // Two strobes inside one frame: one overrun, last sample wins
    run_frame(1'b0, 16'h0, 3, 16'h0100, 5, 16'h8000, -1, 16'hB800, sds, lds);
    chk("ovr_cur_sd", {16'd0, sds}, 32'h0000B800);
    chk("ovr_cnt", ov_cnt, 32'd1);
    run_frame(1'b0, 16'h0, -1, 16'h0, -1, 16'h0, -1, 16'hE000, sds, lds);
    chk("ovr_next_sd", {16'd0, sds}, 32'h0000E000);

    // Strobe on the frame-start cen is bypassed into that frame
    run_frame(1'b1, 16'hFFFF, -1, 16'h0, -1, 16'h0, -1, 16'h2FF8, sds, lds);
    chk("byp_sd", {16'd0, sds}, 32'h00002FF8);
    chk("byp_ov", ov_cnt, 32'd1);

    // cen stalled for 100 clk mid-frame
    run_frame(1'b0, 16'h0, -1, 16'h0, -1, 16'h0, 7, 16'h2FF8, sds, lds);
    chk("stall_frame_sd", {16'd0, sds}, 32'h00002FF8);
    chk("stall_frame_ld", {16'd0, lds}, 32'h00008000);

    // Reset at slot 7: outputs clear asynchronously, then stay quiet
    for (int i = 0; i < 8; i++) slot(1'b0, 16'h0);
    chk("pre_rst_sd", {31'd0, sd}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_sd", {31'd0, sd}, 32'd0);
    chk("arst_ld", {31'd0, ld}, 32'd0);
    step(1'b0, 1'b0, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    sd_or = 1'b0; ld_or = 1'b0;
    for (int i = 0; i < 20; i++) begin
      slot(1'b0, 16'h0);
      sd_or |= sd; ld_or |= ld;
    end
    chk("postrst_sd", {31'd0, sd_or}, 32'd0);
    chk("postrst_ld", {31'd0, ld_or}, 32'd0);
    step(1'b0, 1'b1, 16'h0000);
    run_frame(1'b0, 16'h0, -1, 16'h0, -1, 16'h0, -1, 16'h3000, sds, lds);
    chk("postrst_frame_sd", {16'd0, sds}, 32'h00003000);
    chk("postrst_frame_ld", {16'd0, lds}, 32'h00008000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
